div_rs: RTL
===========

# div_rs

Unsigned integer divider by repeated subtraction, partitioned into a datapath (dividend/remainder register, divisor register, quotient counter, subtractor, comparator) and a controller FSM. It is the inverse companion of the repeated-addition multiplier and uses the same operand-loading scheme: two words arrive over one shared `data_in` bus on consecutive cycles. The block sits beside the multiplier as a standalone arithmetic unit, handshaked by `start`/`done`.

## Interface
- `WIDTH`, 16, operand, quotient and remainder width in bits.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins an operation; sampled in IDLE or DONE.
- `data_in`  in  WIDTH  dividend on the `start` cycle, divisor on the following cycle.
- `quotient`  out  WIDTH  quotient register; valid while `done`=1.
- `remainder`  out  WIDTH  remainder register; valid while `done`=1.
- `done`  out  1  result valid; high in DONE state only.
- `div_by_zero`  out  1  registered flag; divisor was 0 (see Configuration).

## Operation
- Registers: R (dividend, then remainder), B (divisor), Q (quotient counter). All arithmetic is unsigned, WIDTH bits, with no wrap.
- FSM states: IDLE, LOAD_B, CHECK, SUB, DONE.
  - IDLE: if `start`=1, then R<=`data_in` and go to LOAD_B.
  - LOAD_B: B<=`data_in`, Q<=0, `div_by_zero`<=0, then go to CHECK.
  - CHECK: zero test when enabled (see Configuration). Otherwise go to SUB.
  - SUB: if R>=B and Q!=all-ones, then R<=R−B, Q<=Q+1, and stay in SUB. Otherwise go to DONE.
  - DONE: `done`=1 and all registers hold. If `start`=1, then R<=`data_in` and go to LOAD_B (back-to-back operation).
- `start` is ignored in LOAD_B, CHECK and SUB. There is no abort except `rst_n`.
- Q saturation guard (stop at all-ones) is always present, so SUB always terminates.
- Outputs: `quotient`=Q, `remainder`=R, `done`=(state==DONE). No output is driven combinationally from inputs.

## Timing
- Reset (asynchronous, effective immediately, including mid-operation): state=IDLE, R=B=Q=0, `done`=0, `div_by_zero`=0.
- Latency from the edge that samples `start` to the edge that raises `done`: Q+4 edges (LOAD_B, CHECK, Q subtraction edges, 1 exit edge, plus the start edge). For dividend < divisor: 4 edges.
- `data_in` must hold the dividend at start-sample edge N and the divisor at edge N+1. It is don't-care otherwise.
- `done` stays high until the edge that samples the next `start`, then it is low from LOAD_B onward.

## Configuration
- `DIV_RS_ZERO_CHECK_EN` defined:
  - CHECK with B==0 sets Q<=all-ones and `div_by_zero`<=1, leaves R = dividend, and goes to DONE.
  - `done` rises 3 edges after the start sample.
- Not defined:
  - CHECK always goes to SUB.
  - Divisor 0 runs until the saturation guard stops it: Q=all-ones, R=dividend, `div_by_zero` held 0.
  - Latency is 2^WIDTH+3 edges.

## Structure
- Package `div_rs_pkg`: the state enum (IDLE, LOAD_B, CHECK, SUB, DONE) and the default width constant.
- Sub-module `div_rs_datapath`: holds R, B and Q; exposes comparator outputs `r_ge_b`, `b_zero` and `q_max`; takes load, subtract and clear controls.
- Top `div_rs`: contains the controller FSM and instantiates the datapath.

## Test plan
- 17 ÷ 5: `start` with `data_in`=17, then 5 → `done` after 7 edges, Q=3, R=2, `div_by_zero`=0.
- 5 ÷ 17 → `done` after 4 edges, Q=0, R=5.
- 143 ÷ 13 → `done` after 15 edges, Q=11, R=0. Then `start` in DONE with 100 ÷ 7 → Q=14, R=2, with `done` low during the run.
- 17 ÷ 0 with `DIV_RS_ZERO_CHECK_EN` → `done` after 3 edges, Q=0xFFFF, R=17, `div_by_zero`=1. Without the macro → Q=0xFFFF, R=17, `div_by_zero`=0 after 65539 edges.
- `rst_n` pulsed low mid-SUB of 1000 ÷ 3 → outputs 0 immediately, no `done`. Then 1000 ÷ 3 from IDLE → Q=333, R=1.
- `start` held high throughout 17 ÷ 5 → operand words are not re-sampled during the run. Result Q=3, R=2, then an immediate restart from DONE.

Source files
------------

// File: rtl/div_rs_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : div_rs_pkg
// Purpose  : Shared types and constants for the repeated-subtraction divider.
//            - C_WIDTH : default operand/result width
//            - state_e : controller states
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package div_rs_pkg;

    localparam int C_WIDTH = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_B = 3'd1,
        S_CHECK  = 3'd2,
        S_SUB    = 3'd3,
        S_DONE   = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/div_rs_datapath.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : div_rs_datapath
// Purpose  : Register file and arithmetic for the repeated-subtraction divider.
//            Holds R (dividend/remainder), B (divisor) and Q (quotient count).
// Ports    : clk, rst_n       clock, async active-low reset
//            load_r, load_b   capture data_in into R / B
//            clr_q            clear Q
//            set_q_max        force Q to all-ones (divide-by-zero result)
//            sub_en           R <= R - B, Q <= Q + 1
//            data_in          shared operand bus
//            r_val, q_val     current R and Q
//            r_ge_b, b_zero, q_max   comparator outputs for the controller
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module div_rs_datapath
    import div_rs_pkg::*;
#(
    parameter int WIDTH = C_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_r,
    input  logic             load_b,
    input  logic             clr_q,
    input  logic             set_q_max,
    input  logic             sub_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] r_val,
    output logic [WIDTH-1:0] q_val,
    output logic             r_ge_b,
    output logic             b_zero,
    output logic             q_max
);

    localparam logic [WIDTH-1:0] C_ALL_ONES = '1;
    localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quo_q, quo_d;

    always_comb begin
        rem_d = rem_q;
        div_d = div_q;
        quo_d = quo_q;

        if (load_r) begin
            rem_d = data_in;
        end else if (sub_en) begin
            rem_d = rem_q - div_q;
        end

        if (load_b) begin
            div_d = data_in;
        end

        if (clr_q) begin
            quo_d = '0;
        end else if (set_q_max) begin
            quo_d = C_ALL_ONES;
        end else if (sub_en) begin
            quo_d = quo_q + C_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            div_q <= '0;
            quo_q <= '0;
        end else begin
            rem_q <= rem_d;
            div_q <= div_d;
            quo_q <= quo_d;
        end
    end

    assign r_ge_b = (rem_q >= div_q);
    assign b_zero = (div_q == '0);
    // Saturation guard: stops SUB even when B is 0 and R never shrinks.
    assign q_max  = (quo_q == C_ALL_ONES);
    assign r_val  = rem_q;
    assign q_val  = quo_q;

endmodule
`default_nettype wire

// File: rtl/div_rs.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : div_rs
// Purpose  : Unsigned divider by repeated subtraction. Dividend arrives on
//            data_in with start, divisor on the following cycle; done marks
//            a valid quotient/remainder.
// Macro    : DIV_RS_ZERO_CHECK_EN - when defined, a zero divisor is detected
//            in CHECK and finishes immediately with Q=all-ones and
//            div_by_zero=1. When undefined, a zero divisor runs until the
//            quotient saturation guard stops it.
// Ports    : clk, rst_n               clock, async active-low reset
//            start                    begin operation (IDLE/DONE only)
//            data_in [WIDTH-1:0]      dividend, then divisor
//            quotient, remainder      result registers
//            done                     high in DONE state
//            div_by_zero              registered zero-divisor flag
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module div_rs
    import div_rs_pkg::*;
#(
    parameter int WIDTH = C_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             div_by_zero
);

`ifdef DIV_RS_ZERO_CHECK_EN
    localparam bit C_ZERO_CHECK_EN = 1'b1;
`else
    localparam bit C_ZERO_CHECK_EN = 1'b0;
`endif

    state_e state_q, state_d;
    logic   dbz_q, dbz_d;

    logic w_load_r, w_load_b, w_clr_q, w_set_q_max, w_sub_en;
    logic w_r_ge_b, w_b_zero, w_q_max;
    logic w_zero_stop;
    logic w_sub_go;

    assign w_zero_stop = C_ZERO_CHECK_EN & w_b_zero;
    assign w_sub_go    = w_r_ge_b & ~w_q_max;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_CHECK;
            S_CHECK:  state_d = w_zero_stop ? S_DONE : S_SUB;
            S_SUB:    if (!w_sub_go) state_d = S_DONE;
            S_DONE:   if (start) state_d = S_LOAD_B;
            default:  state_d = S_IDLE;
        endcase
    end

    // Control outputs
    always_comb begin
        w_load_r    = 1'b0;
        w_load_b    = 1'b0;
        w_clr_q     = 1'b0;
        w_set_q_max = 1'b0;
        w_sub_en    = 1'b0;
        dbz_d       = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: w_load_r = start;
            S_LOAD_B: begin
                w_load_b = 1'b1;
                w_clr_q  = 1'b1;
                dbz_d    = 1'b0;
            end
            S_CHECK: begin
                if (w_zero_stop) begin
                    w_set_q_max = 1'b1;
                    dbz_d       = 1'b1;
                end
            end
            S_SUB:    w_sub_en = w_sub_go;
            default:  ;
        endcase
    end

    div_rs_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_r    (w_load_r),
        .load_b    (w_load_b),
        .clr_q     (w_clr_q),
        .set_q_max (w_set_q_max),
        .sub_en    (w_sub_en),
        .data_in   (data_in),
        .r_val     (remainder),
        .q_val     (quotient),
        .r_ge_b    (w_r_ge_b),
        .b_zero    (w_b_zero),
        .q_max     (w_q_max)
    );

    assign done        = (state_q == S_DONE);
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
